// File: rtl/rvga_types_pkg.sv
// Shared types for the rvga pipeline hazard controller.
package rvga_types;

  localparam int reg_addr_width_lp = 5;

  typedef enum logic [1:0] {
    HZ_IDLE = 2'd0,
    HZ_WAIT = 2'd1,
    HZ_ERR  = 2'd2
  } rvga_hazard_state_e;

  typedef logic [reg_addr_width_lp-1:0] rvga_reg_addr;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic memwb_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } rvga_pipe_ctrl_s;

endpackage

// File: rtl/rvga_dmem_wait_fsm.sv
// Tracks multi-cycle data-memory accesses with a timeout; ERR is sticky until reset.
module rvga_dmem_wait_fsm
  import rvga_types::*;
#(
  parameter int timeout_p       = 255,
  parameter int timeout_width_p = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  input  logic dmem_resp_v_i,
  output logic mem_stall_v_o,
  output logic mem_err_o
);

  localparam logic [timeout_width_p-1:0] timeout_lp = timeout_width_p'(timeout_p);

  rvga_hazard_state_e         state_r, state_n;
  logic [timeout_width_p-1:0] cnt_r, cnt_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= HZ_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r;
    mem_stall_v_o = 1'b0;
    mem_err_o     = 1'b0;
    case (state_r)
      HZ_IDLE: begin
        if (mem_req_i && !dmem_resp_v_i) begin
          state_n       = HZ_WAIT;
          cnt_n         = timeout_width_p'(1);
          mem_stall_v_o = 1'b1;
        end
      end
      HZ_WAIT: begin
        // the response cycle releases the stall so memwb captures the data
        if (dmem_resp_v_i) begin
          state_n = HZ_IDLE;
          cnt_n   = '0;
        end else begin
          mem_stall_v_o = 1'b1;
          if (cnt_r == timeout_lp) state_n = HZ_ERR;
          else                     cnt_n   = cnt_r + timeout_width_p'(1);
        end
      end
      HZ_ERR: begin
        mem_stall_v_o = 1'b1;
        mem_err_o     = 1'b1;
      end
      default: state_n = HZ_IDLE;
    endcase
  end

endmodule

// File: rtl/rvga_hazard_ctrl.sv
// Stall/flush priority logic for the five-stage rvga pipeline plus stall/flush cycle counters.
module rvga_hazard_ctrl
  import rvga_types::*;
#(
  parameter int reg_addr_width_p = 5,
  parameter int timeout_p        = 255,
  parameter int timeout_width_p  = 8,
  parameter int cnt_width_p      = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [reg_addr_width_p-1:0] id_rs1_i,
  input  logic                        id_rs1_v_i,
  input  logic [reg_addr_width_p-1:0] id_rs2_i,
  input  logic                        id_rs2_v_i,
  input  logic [reg_addr_width_p-1:0] ex_rd_i,
  input  logic                        ex_v_i,
  input  logic                        ex_is_load_i,
  input  logic                        mem_req_i,
  input  logic                        dmem_resp_v_i,
  input  logic                        btaken_i,
  output logic                        pc_stall_v_o,
  output logic                        ifid_stall_v_o,
  output logic                        idex_stall_v_o,
  output logic                        exmem_stall_v_o,
  output logic                        memwb_stall_v_o,
  output logic                        ifid_flush_o,
  output logic                        idex_flush_o,
  output logic                        exmem_flush_o,
  output logic                        mem_err_o,
  output logic [cnt_width_p-1:0]      stall_cnt_o,
  output logic [cnt_width_p-1:0]      flush_cnt_o
);

  logic            mem_stall_v;
  logic            load_use_v;
  logic            any_flush;
  rvga_pipe_ctrl_s ctrl;

  rvga_dmem_wait_fsm #(
    .timeout_p       (timeout_p),
    .timeout_width_p (timeout_width_p)
  ) u_wait_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_i     (mem_req_i),
    .dmem_resp_v_i (dmem_resp_v_i),
    .mem_stall_v_o (mem_stall_v),
    .mem_err_o     (mem_err_o)
  );

  assign load_use_v = ex_v_i && ex_is_load_i && (ex_rd_i != '0)
                   && ((id_rs1_v_i && (id_rs1_i == ex_rd_i))
                    || (id_rs2_v_i && (id_rs2_i == ex_rd_i)));

  // memory stall > branch flush > load-use stall
  always_comb begin
    ctrl = '0;
    if (rst_i) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (mem_stall_v) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      ctrl.memwb_stall = 1'b1;
    end else if (btaken_i) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (load_use_v) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_flush  = 1'b1;
    end
  end

  assign pc_stall_v_o    = ctrl.pc_stall;
  assign ifid_stall_v_o  = ctrl.ifid_stall;
  assign idex_stall_v_o  = ctrl.idex_stall;
  assign exmem_stall_v_o = ctrl.exmem_stall;
  assign memwb_stall_v_o = ctrl.memwb_stall;
  assign ifid_flush_o    = ctrl.ifid_flush;
  assign idex_flush_o    = ctrl.idex_flush;
  assign exmem_flush_o   = ctrl.exmem_flush;

  assign any_flush = ctrl.ifid_flush || ctrl.idex_flush || ctrl.exmem_flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (ctrl.pc_stall) stall_cnt_o <= stall_cnt_o + cnt_width_p'(1);
      if (any_flush)     flush_cnt_o <= flush_cnt_o + cnt_width_p'(1);
    end
  end

endmodule

// File: tb/tb_rvga_hazard_ctrl.sv
// Directed bench for rvga_hazard_ctrl: hazard priorities, dmem wait/timeout and counters.
module tb_rvga_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_rs1_v_i, id_rs2_v_i, ex_v_i, ex_is_load_i;
  logic        mem_req_i, dmem_resp_v_i, btaken_i;
  logic        pc_stall_v_o, ifid_stall_v_o, idex_stall_v_o, exmem_stall_v_o, memwb_stall_v_o;
  logic        ifid_flush_o, idex_flush_o, exmem_flush_o, mem_err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // {pc, ifid, idex, exmem, memwb stalls, ifid, idex, exmem flushes}
  logic [7:0] ctrl;
  assign ctrl = {pc_stall_v_o, ifid_stall_v_o, idex_stall_v_o, exmem_stall_v_o,
                 memwb_stall_v_o, ifid_flush_o, idex_flush_o, exmem_flush_o};

  localparam logic [7:0] C_NONE  = 8'b00000_000;
  localparam logic [7:0] C_MEM   = 8'b11111_000;
  localparam logic [7:0] C_BR    = 8'b00000_111;
  localparam logic [7:0] C_LU    = 8'b11000_010;

  rvga_hazard_ctrl #(
    .reg_addr_width_p (5),
    .timeout_p        (4),
    .timeout_width_p  (8),
    .cnt_width_p      (32)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs1_v_i      (id_rs1_v_i),
    .id_rs2_i        (id_rs2_i),
    .id_rs2_v_i      (id_rs2_v_i),
    .ex_rd_i         (ex_rd_i),
    .ex_v_i          (ex_v_i),
    .ex_is_load_i    (ex_is_load_i),
    .mem_req_i       (mem_req_i),
    .dmem_resp_v_i   (dmem_resp_v_i),
    .btaken_i        (btaken_i),
    .pc_stall_v_o    (pc_stall_v_o),
    .ifid_stall_v_o  (ifid_stall_v_o),
    .idex_stall_v_o  (idex_stall_v_o),
    .exmem_stall_v_o (exmem_stall_v_o),
    .memwb_stall_v_o (memwb_stall_v_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_flush_o    (idex_flush_o),
    .exmem_flush_o   (exmem_flush_o),
    .mem_err_o       (mem_err_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1_i = 5'd0; id_rs1_v_i = 1'b0;
    id_rs2_i = 5'd0; id_rs2_v_i = 1'b0;
    ex_rd_i = 5'd0; ex_v_i = 1'b0; ex_is_load_i = 1'b0;
    mem_req_i = 1'b0; dmem_resp_v_i = 1'b0; btaken_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    mem_req_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BR) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_BR);
    end
    tick(); tick();
    mem_req_i = 1'b0;
    #1;
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0 || mem_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_state got=%0d/%0d/%b exp=0/0/0", stall_cnt_o, flush_cnt_o, mem_err_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL post_reset_ctrl got=%b exp=%b", ctrl, C_NONE);
    end
  endtask

  task automatic test_load_use();
    // rs1 match on x5
    ex_v_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
    id_rs1_i = 5'd5; id_rs1_v_i = 1'b1; id_rs2_i = 5'd7; id_rs2_v_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_LU) begin
      errors++; $display("FAIL load_use_rs1 got=%b exp=%b", ctrl, C_LU);
    end
    tick(); exp_stall++; exp_flush++;
    idle_inputs();
    #1;
    checks++;
    if (ctrl !== C_NONE || stall_cnt_o !== 32'(exp_stall)) begin
      errors++; $display("FAIL load_use_release got=%b cnt=%0d exp=%b cnt=%0d", ctrl, stall_cnt_o, C_NONE, exp_stall);
    end
    // rs2 match; rs1 match with rs1 unused must not matter
    ex_v_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd9;
    id_rs1_i = 5'd9; id_rs1_v_i = 1'b0; id_rs2_i = 5'd9; id_rs2_v_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_LU) begin
      errors++; $display("FAIL load_use_rs2 got=%b exp=%b", ctrl, C_LU);
    end
    tick(); exp_stall++; exp_flush++;
    // rs1 matches but marked unused, rs2 differs: no hazard
    id_rs2_i = 5'd3;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL load_use_unused_src got=%b exp=%b", ctrl, C_NONE);
    end
    // non-load in EX
    id_rs1_v_i = 1'b1; ex_is_load_i = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL load_use_not_load got=%b exp=%b", ctrl, C_NONE);
    end
    // x0 destination never hazards
    ex_is_load_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL load_use_x0 got=%b exp=%b", ctrl, C_NONE);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (stall_cnt_o !== 32'(exp_stall) || flush_cnt_o !== 32'(exp_flush)) begin
      errors++; $display("FAIL load_use_counts got=%0d/%0d exp=%0d/%0d", stall_cnt_o, flush_cnt_o, exp_stall, exp_flush);
    end
  endtask

  task automatic test_branch();
    btaken_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BR) begin
      errors++; $display("FAIL branch_flush got=%b exp=%b", ctrl, C_BR);
    end
    tick(); exp_flush++;
    btaken_i = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NONE || flush_cnt_o !== 32'(exp_flush)) begin
      errors++; $display("FAIL branch_one_cycle got=%b cnt=%0d exp=%b cnt=%0d", ctrl, flush_cnt_o, C_NONE, exp_flush);
    end
  endtask

  task automatic test_mem_wait();
    mem_req_i = 1'b1; btaken_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctrl !== C_MEM) begin
        errors++; $display("FAIL mem_wait_stall cycle=%0d got=%b exp=%b", i, ctrl, C_MEM);
      end
      tick(); exp_stall++;
    end
    dmem_resp_v_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BR) begin
      errors++; $display("FAIL mem_resp_release got=%b exp=%b", ctrl, C_BR);
    end
    tick(); exp_flush++;
    idle_inputs();
    #1;
    checks++;
    if (ctrl !== C_NONE || stall_cnt_o !== 32'(exp_stall) || flush_cnt_o !== 32'(exp_flush)) begin
      errors++; $display("FAIL mem_wait_after got=%b %0d/%0d exp=%b %0d/%0d", ctrl, stall_cnt_o, flush_cnt_o, C_NONE, exp_stall, exp_flush);
    end
    // single-cycle access: request with immediate response never stalls
    mem_req_i = 1'b1; dmem_resp_v_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL mem_one_cycle got=%b exp=%b", ctrl, C_NONE);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_over_load_use();
    ex_v_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd12;
    id_rs1_i = 5'd12; id_rs1_v_i = 1'b1; btaken_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BR) begin
      errors++; $display("FAIL branch_beats_load_use got=%b exp=%b", ctrl, C_BR);
    end
    tick(); exp_flush++;
    idle_inputs();
  endtask

  task automatic test_timeout();
    mem_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (mem_err_o !== 1'b0 || ctrl !== C_MEM) begin
        errors++; $display("FAIL timeout_pre cycle=%0d got err=%b ctrl=%b exp err=0 ctrl=%b", i, mem_err_o, ctrl, C_MEM);
      end
      tick(); exp_stall++;
    end
    mem_req_i = 1'b0; dmem_resp_v_i = 1'b1;
    #1;
    checks++;
    if (mem_err_o !== 1'b1 || ctrl !== C_MEM) begin
      errors++; $display("FAIL timeout_err got err=%b ctrl=%b exp err=1 ctrl=%b", mem_err_o, ctrl, C_MEM);
    end
    tick(); exp_stall++;
    dmem_resp_v_i = 1'b0;
    tick(); exp_stall++;
    checks++;
    if (stall_cnt_o !== 32'(exp_stall) || flush_cnt_o !== 32'(exp_flush)) begin
      errors++; $display("FAIL counts_before_reset got=%0d/%0d exp=%0d/%0d", stall_cnt_o, flush_cnt_o, exp_stall, exp_flush);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BR) begin
      errors++; $display("FAIL err_reset_ctrl got=%b exp=%b", ctrl, C_BR);
    end
    tick();
    checks++;
    if (mem_err_o !== 1'b0 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      errors++; $display("FAIL err_reset_state got err=%b %0d/%0d exp err=0 0/0", mem_err_o, stall_cnt_o, flush_cnt_o);
    end
    rst_i = 1'b0;
    exp_stall = 0; exp_flush = 0;
  endtask

  task automatic test_reset_mid_wait();
    mem_req_i = 1'b1;
    tick();
    rst_i = 1'b1; mem_req_i = 1'b0;
    tick();
    rst_i = 1'b0; dmem_resp_v_i = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_NONE || mem_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait got=%b err=%b exp=%b err=0", ctrl, mem_err_o, C_NONE);
    end
    tick();
    dmem_resp_v_i = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NONE || stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL stray_resp_ignored got=%b cnt=%0d exp=%b cnt=0", ctrl, stall_cnt_o, C_NONE);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_over_load_use();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvga_hazard_ctrl.md
Name: rvga_hazard_ctrl

Overview:
Central stall/flush controller for the five-stage rvga pipeline. It drives the stall_v_i and bubble-insert controls of the PC register and the ifid, idex, exmem and memwb latches. It resolves three hazard sources:
- load-use RAW hazards (decode vs. execute)
- taken branches resolved at the MEM stage
- multi-cycle data-memory accesses, tracked by a timeout-guarded wait FSM

It also keeps wrapping performance counters for stall and flush cycles.

Parameters:
reg_addr_width_p, 5, register-file index width
timeout_p, 255, max dmem wait cycles before error; legal range 1..2^timeout_width_p-1
timeout_width_p, 8, width of wait counter
cnt_width_p, 32, width of performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_rs1_i  in  reg_addr_width_p  decode-stage source 1 index
id_rs1_v_i  in  1  decode uses rs1
id_rs2_i  in  reg_addr_width_p  decode-stage source 2 index
id_rs2_v_i  in  1  decode uses rs2
ex_rd_i  in  reg_addr_width_p  execute-stage destination index
ex_v_i  in  1  execute stage holds valid instruction
ex_is_load_i  in  1  execute instruction is a load
mem_req_i  in  1  MEM stage holds valid load/store (exmem latch output)
dmem_resp_v_i  in  1  data memory completes the access this cycle
btaken_i  in  1  taken branch/jump at MEM stage (exmem latch output)
pc_stall_v_o  out  1  hold PC
ifid_stall_v_o  out  1  hold ifid latch
idex_stall_v_o  out  1  hold idex latch
exmem_stall_v_o  out  1  hold exmem latch
memwb_stall_v_o  out  1  hold memwb latch
ifid_flush_o  out  1  load bubble into ifid
idex_flush_o  out  1  load bubble into idex
exmem_flush_o  out  1  load bubble into exmem
mem_err_o  out  1  sticky dmem timeout error
stall_cnt_o  out  cnt_width_p  cycles with pc_stall_v_o=1
flush_cnt_o  out  cnt_width_p  cycles with any flush asserted

Behaviour:
- Reset (clock and reset port semantics): one clock clk_i; reset rst_i is synchronous and active-high.
- State and counters after reset:
  - FSM = IDLE, wait counter = 0, mem_err_o = 0, stall_cnt_o = 0, flush_cnt_o = 0.
  - While rst_i = 1: all stall outputs = 0 and all flush outputs = 1, so the pipeline fills with bubbles.
- FSM states:
  - IDLE:
    - mem_req_i & ~dmem_resp_v_i -> WAIT, counter <= 1.
    - mem_req_i & dmem_resp_v_i -> stay IDLE; the access takes one cycle with no stall.
  - WAIT:
    - dmem_resp_v_i -> IDLE.
    - else counter == timeout_p -> ERR.
    - else counter <= counter + 1.
  - ERR: absorbing until reset; mem_err_o = 1.
- Memory stall (highest priority): asserted when (state==IDLE & mem_req_i & ~dmem_resp_v_i) | state==WAIT | state==ERR.
  - All five stall outputs = 1; all flushes = 0.
  - Release is combinational: in the cycle dmem_resp_v_i=1 the stalls drop, so the response is captured by memwb on that edge.
- Branch flush (second priority, no memory stall):
  - btaken_i=1 -> ifid_flush_o, idex_flush_o and exmem_flush_o = 1; all stalls = 0.
  - A btaken_i arriving during a memory stall is deferred; it remains stable because exmem is frozen.
- Load-use stall (third priority):
  - Condition: ex_v_i & ex_is_load_i & ex_rd_i!=0 & ((id_rs1_v_i & id_rs1_i==ex_rd_i) | (id_rs2_v_i & id_rs2_i==ex_rd_i)).
  - Response: pc and ifid stalled, idex_flush_o=1; exmem and memwb advance.
  - The condition clears on the next cycle, so the stall lasts one cycle per hazard.
  - A branch flush in the same cycle overrides it: the hazarding instruction is squashed.
- Outputs are combinational from FSM state plus inputs. The FSM, wait counter, error flag and performance counters are registered.
- Performance counters increment on the clock edge when their condition holds. They wrap modulo 2^cnt_width_p and do not increment during reset.
- Reset mid-WAIT: FSM returns to IDLE next cycle; the pending access is abandoned and a later dmem_resp_v_i in IDLE without mem_req_i is ignored.
- The ERR state freezes the pipeline permanently.

Decomposition:
- The rvga_types package gets:
  - rvga_hazard_state_e enum (IDLE, WAIT, ERR);
  - a rvga_reg_addr typedef of width reg_addr_width_p;
  - an rvga_pipe_ctrl_s struct bundling the stall/flush bits for the latch controls.
- One sub-module, rvga_dmem_wait_fsm, holds the FSM, wait counter and mem_err_o. It outputs mem_stall_v to the priority logic.
- Counters reuse the existing dff with an adder; no new sub-module.

Test Plan:
- Load x5 in EX, decode add reading rs1=x5 -> one cycle with pc/ifid stall=1 and idex_flush_o=1, then release; stall_cnt_o=1.
- Load x0 in EX, decode reads x0 -> no stall, no flush.
- btaken_i=1 for one cycle with no memory request -> ifid/idex/exmem flush=1 for that cycle only; flush_cnt_o increments by 1.
- mem_req_i=1, dmem_resp_v_i after 3 cycles -> all stalls=1 for 3 cycles and drop in the response cycle; btaken_i held during the wait is flushed only after release.
- timeout_p=4, mem_req_i held with no response -> ERR after 4 WAIT cycles, mem_err_o=1, stalls stay 1; rst_i=1 -> mem_err_o=0, counters=0, flushes=1 during reset.
- Load-use hazard and btaken_i in the same cycle -> flush wins: three flushes asserted, pc_stall_v_o=0.
